// File: rtl/clock_ce_gen_pkg.sv
// Shared definitions for the clock-enable generator: FSM encoding and
// settle counter sizing.
package clock_ce_gen_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // Settle counter must be able to hold LOCK_WAIT-1 down to zero.
  function automatic int settle_cnt_w(input int lock_wait);
    return $clog2(lock_wait + 1);
  endfunction

endpackage

// File: rtl/clock_ce_gen_chan.sv
// One enable channel: config shadows, fractional phase accumulator and
// registered period / mid-period enables.
module clock_ce_gen_chan #(
  parameter int ACC_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_sync,
  input  logic [ACC_W-1:0] i_num,
  input  logic [ACC_W-1:0] i_den,
  output logic             o_ce_p,
  output logic             o_ce_n
);

  logic [ACC_W-1:0] r_num;
  logic [ACC_W-1:0] r_den;
  logic [ACC_W-1:0] r_acc;
  logic             r_ce_p;
  logic             r_ce_n;

  logic [ACC_W-1:0] w_num_nxt;
  logic [ACC_W-1:0] w_den_nxt;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_ce_p_nxt;
  logic             w_ce_n_nxt;

  logic [ACC_W:0]   w_sum;
  logic [ACC_W:0]   w_den_x;
  logic [ACC_W:0]   w_half;
  logic [ACC_W-1:0] w_acc_wrap;
  logic             w_idle;
  logic             w_fast;
  logic             w_wrap;
  logic             w_ce_n_ok;
  logic             w_mid;

  // The sum carries one extra bit so acc + num never overflows.
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_num};
  assign w_den_x    = {1'b0, r_den};
  assign w_half     = (w_den_x + {{ACC_W{1'b0}}, 1'b1}) >> 1;
  // Only used when acc < den and num < den, so the true difference fits ACC_W bits.
  assign w_acc_wrap = w_sum[ACC_W-1:0] - r_den;
  assign w_idle     = (r_num == {ACC_W{1'b0}}) || (r_den == {ACC_W{1'b0}});
  assign w_fast     = (r_num >= r_den);
  assign w_wrap     = (w_sum >= w_den_x);
  // A mid-period pulse only makes sense when a period spans two or more steps past half.
  assign w_ce_n_ok  = ({r_num, 1'b0} <= {1'b0, r_den});
  assign w_mid      = w_ce_n_ok && ({1'b0, r_acc} < w_half) && (w_sum >= w_half) && !w_wrap;

  // Next-state for shadows, accumulator and enables; shadows only move when no period is in flight.
  always_comb begin
    w_num_nxt  = r_num;
    w_den_nxt  = r_den;
    w_acc_nxt  = r_acc;
    w_ce_p_nxt = 1'b0;
    w_ce_n_nxt = 1'b0;
    if (!i_run) begin
      w_acc_nxt = {ACC_W{1'b0}};
      w_num_nxt = i_num;
      w_den_nxt = i_den;
    end else if (i_sync) begin
      w_acc_nxt = {ACC_W{1'b0}};
    end else if (w_idle) begin
      w_acc_nxt = {ACC_W{1'b0}};
    end else if (w_fast) begin
      // Every clock is a period boundary; keep phase at zero so a later slower ratio starts clean.
      w_acc_nxt  = {ACC_W{1'b0}};
      w_ce_p_nxt = 1'b1;
      w_num_nxt  = i_num;
      w_den_nxt  = i_den;
    end else if (w_wrap) begin
      w_acc_nxt  = w_acc_wrap;
      w_ce_p_nxt = 1'b1;
      w_num_nxt  = i_num;
      w_den_nxt  = i_den;
    end else begin
      w_acc_nxt  = w_sum[ACC_W-1:0];
      w_ce_n_nxt = w_mid;
    end
  end

  // Channel state and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_num  <= {ACC_W{1'b0}};
      r_den  <= {ACC_W{1'b0}};
      r_acc  <= {ACC_W{1'b0}};
      r_ce_p <= 1'b0;
      r_ce_n <= 1'b0;
    end else begin
      r_num  <= w_num_nxt;
      r_den  <= w_den_nxt;
      r_acc  <= w_acc_nxt;
      r_ce_p <= w_ce_p_nxt;
      r_ce_n <= w_ce_n_nxt;
    end
  end

  assign o_ce_p = r_ce_p;
  assign o_ce_n = r_ce_n;

endmodule

// File: rtl/clock_ce_gen.sv
// Multi-channel fractional clock-enable generator. Enables are held off
// until the DCM lock has been stable for LOCK_WAIT clocks.
module clock_ce_gen
  import clock_ce_gen_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int ACC_W     = 16,
  parameter int LOCK_WAIT = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      locked,
  input  logic                      sync,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*ACC_W-1:0] num,
  input  logic [CHANNELS*ACC_W-1:0] den,
  output logic [CHANNELS-1:0]       ce_p,
  output logic [CHANNELS-1:0]       ce_n,
  output logic                      ready
);

  localparam int             CNT_W    = settle_cnt_w(LOCK_WAIT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_WAIT - 1);

  logic               r_lock_meta;
  logic               r_lock_sync;
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_ready_nxt;
  logic               w_run;
  logic [CHANNELS-1:0] w_chan_run;

  // Two-flop synchroniser for the asynchronous lock status.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= locked;
      r_lock_sync <= r_lock_meta;
    end
  end

  // Lock FSM next-state: loss of lock wins over every state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = 1'b0;
    if (!r_lock_sync) begin
      w_state_nxt = ST_WAIT_LOCK;
      w_cnt_nxt   = {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = CNT_LOAD;
        end
        ST_SETTLE: begin
          if (r_cnt == {CNT_W{1'b0}}) begin
            w_state_nxt = ST_RUN;
            w_ready_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          w_ready_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Lock FSM state, settle counter and ready registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_WAIT_LOCK;
      r_cnt   <= {CNT_W{1'b0}};
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Gating with the synchronised lock makes the channels go quiet on the same edge as ready.
  assign w_run      = (r_state == ST_RUN) && r_lock_sync;
  assign w_chan_run = {CHANNELS{w_run}} & enable;
  assign ready      = r_ready;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    clock_ce_gen_chan #(
      .ACC_W (ACC_W)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .i_run  (w_chan_run[k]),
      .i_sync (sync),
      .i_num  (num[k*ACC_W +: ACC_W]),
      .i_den  (den[k*ACC_W +: ACC_W]),
      .o_ce_p (ce_p[k]),
      .o_ce_n (ce_n[k])
    );
  end

endmodule

// File: tb/tb_clock_ce_gen.sv
// Scoreboard bench for clock_ce_gen: stimulus pushes expected pulse cycles,
// a negedge monitor pops and compares every observed pulse / ready change.
module tb_clock_ce_gen;

  localparam int LW = 16;

  logic        clock;
  logic        reset;
  logic        locked;
  logic        sync;
  logic [1:0]  enable;
  logic [31:0] num;
  logic [31:0] den;
  logic [1:0]  ce_p;
  logic [1:0]  ce_n;
  logic        ready;

  typedef struct {
    int         cyc;
    logic       rdy;
    logic [1:0] p;
    logic [1:0] n;
  } lvl_t;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   q_ev[4][$];   // 0: ce_p[0], 1: ce_n[0], 2: ce_p[1], 3: ce_n[1]
  int   q_rdy[$];     // cycle*2 + new ready value
  lvl_t q_lvl[$];
  logic prev_rdy = 1'b0;

  clock_ce_gen #(.CHANNELS(2), .ACC_W(16), .LOCK_WAIT(LW)) dut (
    .clock  (clock),
    .reset  (reset),
    .locked (locked),
    .sync   (sync),
    .enable (enable),
    .num    (num),
    .den    (den),
    .ce_p   (ce_p),
    .ce_n   (ce_n),
    .ready  (ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic string ev_name(input int j);
    case (j)
      0:       return "ce_p0";
      1:       return "ce_n0";
      2:       return "ce_p1";
      default: return "ce_n1";
    endcase
  endfunction

  // Monitor: the only process that compares and counts.
  always @(negedge clock) begin : mon
    logic hit;
    lvl_t e;
    for (int j = 0; j < 4; j++) begin
      hit = (j % 2 == 0) ? ce_p[j/2] : ce_n[j/2];
      while (q_ev[j].size() > 0 && q_ev[j][0] < cyc) begin
        n_checks++; n_errors++;
        $display("FAIL %s missed: expected pulse at cycle %0d did not occur", ev_name(j), q_ev[j][0]);
        void'(q_ev[j].pop_front());
      end
      if (hit) begin
        n_checks++;
        if (q_ev[j].size() > 0 && q_ev[j][0] == cyc) begin
          void'(q_ev[j].pop_front());
        end else begin
          n_errors++;
          $display("FAIL %s unexpected: pulse at cycle %0d, next expected %0d", ev_name(j), cyc,
                   (q_ev[j].size() > 0) ? q_ev[j][0] : -1);
        end
      end
    end
    while (q_rdy.size() > 0 && q_rdy[0] / 2 < cyc) begin
      n_checks++; n_errors++;
      $display("FAIL ready missed: expected ready=%0d at cycle %0d, no change seen", q_rdy[0] % 2, q_rdy[0] / 2);
      void'(q_rdy.pop_front());
    end
    if (ready !== prev_rdy) begin
      n_checks++;
      if (q_rdy.size() > 0 && q_rdy[0] == cyc * 2 + int'(ready)) begin
        void'(q_rdy.pop_front());
      end else begin
        n_errors++;
        $display("FAIL ready change: ready=%b at cycle %0d, next expected code %0d", ready, cyc,
                 (q_rdy.size() > 0) ? q_rdy[0] : -1);
      end
    end
    prev_rdy = ready;
    while (q_lvl.size() > 0 && q_lvl[0].cyc <= cyc) begin
      e = q_lvl.pop_front();
      n_checks++;
      if (e.cyc != cyc || ready !== e.rdy || ce_p !== e.p || ce_n !== e.n) begin
        n_errors++;
        $display("FAIL level@%0d: got ready=%b ce_p=%b ce_n=%b at cycle %0d, want ready=%b ce_p=%b ce_n=%b",
                 e.cyc, ready, ce_p, ce_n, cyc, e.rdy, e.p, e.n);
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic set_cfg(input int ch, input int n, input int d);
    num[ch*16 +: 16] = 16'(n);
    den[ch*16 +: 16] = 16'(d);
  endtask

  task automatic push_lvl(input int c, input logic r, input logic [1:0] p, input logic [1:0] n);
    lvl_t e;
    e.cyc = c; e.rdy = r; e.p = p; e.n = n;
    q_lvl.push_back(e);
  endtask

  // Expected pulses for ratio n/d stepping from phase 0 at edge rf+1:
  // ce_p at rf+ceil(k*d/n), ce_n at rf+ceil((k*d+half)/n), kept within [lo, hi].
  task automatic push_chan(input int ch, input int rf, input int n, input int d, input int lo, input int hi);
    int t;
    int h;
    if (n > 0 && d > 0) begin
      if (n >= d) begin
        for (int k = 1; rf + k <= hi; k++) if (rf + k >= lo) q_ev[2*ch].push_back(rf + k);
      end else begin
        for (int k = 1; k < 20000; k++) begin
          t = rf + (k * d + n - 1) / n;
          if (t > hi) break;
          if (t >= lo) q_ev[2*ch].push_back(t);
        end
        if (2 * n <= d) begin
          h = (d + 1) / 2;
          for (int k = 0; k < 20000; k++) begin
            t = rf + (k * d + h + n - 1) / n;
            if (t > hi) break;
            if (t >= lo) q_ev[2*ch+1].push_back(t);
          end
        end
      end
    end
  endtask

  initial begin : stim
    int r; int w; int s; int y; int x; int z;
    reset = 1'b0; locked = 1'b1; sync = 1'b0; enable = 2'b11; num = 32'd0; den = 32'd0;
    set_cfg(0, 1, 3); set_cfg(1, 1, 8);
    push_lvl(2, 1'b0, 2'b00, 2'b00);

    // T1: lock present from reset release; ready after sync + settle.
    wait_to(4); reset = 1'b1;
    r = 4 + LW + 3;
    q_rdy.push_back(r * 2 + 1);
    push_lvl(r, 1'b1, 2'b00, 2'b00);
    push_lvl(r + 24, 1'b1, 2'b11, 2'b00);
    w = r + 48;
    push_chan(0, r, 1, 3, r + 1, w); push_chan(1, r, 1, 8, r + 1, w);
    wait_to(w); enable = 2'b00;

    // T3: 1/16 and 1/8, then sync realigns both.
    wait_to(w + 2); set_cfg(0, 1, 16); set_cfg(1, 1, 8);
    s = w + 4; wait_to(s); enable = 2'b11;
    y = s + 20;
    push_lvl(s + 16, 1'b1, 2'b11, 2'b00);
    push_chan(0, s, 1, 16, s + 1, y);       push_chan(1, s, 1, 8, s + 1, y);
    push_chan(0, y + 1, 1, 16, y + 2, y + 41); push_chan(1, y + 1, 1, 8, y + 2, y + 41);
    wait_to(y); sync = 1'b1;
    wait_to(y + 1); sync = 1'b0;
    w = y + 41; wait_to(w); enable = 2'b00;

    // T4: den 16 -> 4 mid-period; the running period still ends at 16.
    wait_to(w + 2); set_cfg(0, 1, 16);
    s = w + 4; wait_to(s); enable = 2'b01;
    push_chan(0, s, 1, 16, s + 1, s + 16);
    push_chan(0, s + 16, 1, 4, s + 17, s + 56);
    wait_to(s + 5); set_cfg(0, 1, 4);
    w = s + 56; wait_to(w); enable = 2'b00;

    // T2: 7/100 for 10000 clocks (700 pulses); ch1 3/5 has no ce_n.
    wait_to(w + 2); set_cfg(0, 7, 100); set_cfg(1, 3, 5);
    s = w + 4; wait_to(s); enable = 2'b11;
    push_lvl(s + 15, 1'b1, 2'b11, 2'b00);
    push_chan(0, s, 7, 100, s + 1, s + 10000); push_chan(1, s, 3, 5, s + 1, s + 10000);
    w = s + 10000; wait_to(w); enable = 2'b00;

    // Corners: num=0 silent, num=den pulses every clock.
    wait_to(w + 2); set_cfg(0, 0, 5); set_cfg(1, 4, 4);
    s = w + 4; wait_to(s); enable = 2'b11;
    push_lvl(s + 5, 1'b1, 2'b10, 2'b00);
    push_chan(0, s, 0, 5, s + 1, s + 20); push_chan(1, s, 4, 4, s + 1, s + 20);
    w = s + 20; wait_to(w); enable = 2'b00;

    // T5: lock lost for 3 clocks in RUN, then relock and full settle.
    wait_to(w + 2); set_cfg(0, 1, 3); set_cfg(1, 1, 8);
    s = w + 4; wait_to(s); enable = 2'b11;
    x = s + 10;
    push_chan(0, s, 1, 3, s + 1, x + 2); push_chan(1, s, 1, 8, s + 1, x + 2);
    q_rdy.push_back((x + 3) * 2);
    push_lvl(x + 3, 1'b0, 2'b00, 2'b00);
    r = x + 3 + LW + 3;
    q_rdy.push_back(r * 2 + 1);
    push_chan(0, r, 1, 3, r + 1, r + 30); push_chan(1, r, 1, 8, r + 1, r + 30);
    wait_to(x); locked = 1'b0;
    wait_to(x + 3); locked = 1'b1;
    w = r + 30; wait_to(w); enable = 2'b00;

    // T6: asynchronous reset mid-cycle while ch1 pulses every clock.
    wait_to(w + 2); set_cfg(0, 1, 3); set_cfg(1, 4, 4);
    s = w + 4; wait_to(s); enable = 2'b11;
    z = s + 7;
    push_chan(0, s, 1, 3, s + 1, z - 1); push_chan(1, s, 4, 4, s + 1, z - 1);
    push_lvl(z - 1, 1'b1, 2'b11, 2'b00);
    q_rdy.push_back(z * 2);
    push_lvl(z, 1'b0, 2'b00, 2'b00);
    wait_to(z - 1);
    @(posedge clock);
    #2 reset = 1'b0;
    wait_to(z + 4);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
